wb_test_slave: RTL and testbench
================================

# wb_test_slave

Four-register Wishbone B3 slave used as a bus-fabric test target. Sits behind the Wishbone switch as an addressable endpoint (e.g. 0x9000_0000 window), accepting classic single-cycle and incrementing-burst transfers from the BFM master. Provides byte-lane writes, registered read-back and registered acknowledge so fabric routing and burst handling can be checked end to end.

## Interface
- Parameters
- `AW`, default 32, address width.
- `DW`, default 32, data width; `DW/8` byte lanes.
- Ports
- `wb_clk` in 1: single clock, all logic on rising edge.
- `wb_rst` in 1: reset, synchronous, active-high.
- `wb_adr_i` in AW: byte address; only `[3:2]` decoded, upper bits ignored (decoded by interconnect).
- `wb_dat_i` in DW: write data.
- `wb_sel_i` in DW/8: byte enables.
- `wb_we_i` in 1: 1 = write.
- `wb_cyc_i`, `wb_stb_i` in 1: cycle / strobe.
- `wb_cti_i` in 3: cycle type (000 classic, 001 constant, 010 incrementing, 111 end-of-burst).
- `wb_bte_i` in 2: burst type (00 linear, 01/10/11 wrap 4/8/16).
- `wb_dat_o` out DW: read data, registered.
- `wb_ack_o` out 1: acknowledge, registered.
- `wb_err_o` out 1: error, registered.
- `wb_rty_o` out 1: retry, constant 0.

## Operation
- Storage: `reg[0..3]`, DW bits each, index = `adr[3:2]`; reset value 0x0000_0000.
- Request valid when `wb_cyc_i & wb_stb_i`.
- Write: on the acking edge, for each lane `i` with `wb_sel_i[i]=1`, `reg[idx][8i+7:8i] <= wb_dat_i[8i+7:8i]`; unselected lanes keep value.
- Read: `wb_dat_o <= reg[idx]` on the acking edge; `wb_sel_i` ignored for reads (full word returned). `wb_dat_o` holds last value between transfers.
- Cycle types 000, 001, 111 (when not in burst) -> classic handling. 010 -> incrementing burst. 011–110 reserved -> `wb_err_o` pulse instead of ack, no register change.
- Burst: slave keeps internal beat index; after each acked beat, next index = idx+1 modulo 4 (all bte modes reduce to mod-4 wrap at 4 registers). Burst ends on beat with `cti=111` or on `cyc/stb` deassert.
- Any `wb_bte_i` value accepted.

## Timing
- Reset: `wb_ack_o=0`, `wb_err_o=0`, `wb_rty_o=0`, `wb_dat_o=0`, registers 0, FSM IDLE. Reset mid-transfer aborts it; no ack on that cycle.
- FSM: IDLE -> ACK (classic) or BURST (cti=010) when request valid and ack low.
- Classic: request seen at edge N -> `wb_ack_o=1` during cycle N+1 -> forced 0 at N+2 even if stb still high (no double ack); new request may be acked again at N+3.
- Burst: first ack cycle N+1, then ack every cycle while stb high and cti=010; beat with `cti=111` acked, then ack drops, FSM IDLE. Read data per beat uses internal predicted index, matching master address sequence.
- stb dropped mid-burst: ack deasserts next cycle, no write on unacked beat; FSM IDLE when `cyc` low.
- Error: single-cycle `wb_err_o`, same latency as ack; ack and err never both high.

## Structure
- Shared package `wb_pkg`: CTI codes (CLASSIC, CONST, INCR, EOB), BTE codes, `NUM_REGS=4`.
- Sub-module `wb_burst_addr`: computes next word index from current index and bte (wrap masks).
- Top: FSM, register array with byte-lane write, output registers.

## Test plan
- Reset, classic read of all 4 offsets -> each returns 0x0000_0000, ack 1 cycle.
- Classic writes sel=F: 0x0 <- 0xDEADBEEF, 0x4 <- 0xF00DD00F, 0x8 <- 0x01234567, 0xC <- 0x89ABCDEF; single reads (cti=111) return the same values, err=0.
- Byte lanes: write 0x11223344 to 0x0 with sel=0x5 over 0xDEADBEEF -> read 0xDE22BE44.
- Incrementing burst read from 0x8, 4 beats (last cti=111) -> 0x01234567, 0x89ABCDEF, 0xDEADBEEF, 0xF00DD00F, ack on 4 consecutive cycles then 0.
- Hold stb high after classic ack -> ack high exactly 1 cycle; cti=011 request -> err 1 cycle, ack 0, registers unchanged.
- Assert `wb_rst` mid-burst -> ack/err 0 next cycle, all registers read back 0.

Source files
------------

// File: rtl/wb_test_slave_pkg.sv
// Shared definitions for the Wishbone test slave: cycle/burst type codes,
// register count, FSM states and small decode helpers.
package wb_pkg;

  localparam int NUM_REGS = 4;
  localparam int IDX_W    = $clog2(NUM_REGS);

  typedef enum logic [2:0] {
    CTI_CLASSIC = 3'b000,
    CTI_CONST   = 3'b001,
    CTI_INCR    = 3'b010,
    CTI_EOB     = 3'b111
  } cti_e;

  typedef enum logic [1:0] {
    BTE_LINEAR = 2'b00,
    BTE_WRAP4  = 2'b01,
    BTE_WRAP8  = 2'b10,
    BTE_WRAP16 = 2'b11
  } bte_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACK,
    ST_BURST
  } state_e;

  // Address bits allowed to change inside a burst; linear bursts may roll over freely.
  function automatic logic [3:0] bteWrapMask(input logic [1:0] bte);
    case (bte)
      BTE_WRAP4:  return 4'h3;
      BTE_WRAP8:  return 4'h7;
      BTE_WRAP16: return 4'hF;
      default:    return 4'hF;
    endcase
  endfunction

  function automatic logic isReservedCti(input logic [2:0] cti);
    return !(cti == CTI_CLASSIC || cti == CTI_CONST ||
             cti == CTI_INCR    || cti == CTI_EOB);
  endfunction

endpackage

// File: rtl/wb_test_slave_if.sv
// Wishbone B3 bus bundle between a master and the test slave.
interface wb_test_slave_if #(
  parameter int AW = 32,
  parameter int DW = 32
);

  logic [AW-1:0]   wb_adr_i;
  logic [DW-1:0]   wb_dat_i;
  logic [DW/8-1:0] wb_sel_i;
  logic            wb_we_i;
  logic            wb_cyc_i;
  logic            wb_stb_i;
  logic [2:0]      wb_cti_i;
  logic [1:0]      wb_bte_i;
  logic [DW-1:0]   wb_dat_o;
  logic            wb_ack_o;
  logic            wb_err_o;
  logic            wb_rty_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
    input  wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
    output wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
  );

endinterface

// File: rtl/wb_test_slave_burst_addr.sv
// Next word index of a burst: increment inside the wrap window selected by bte,
// which with four registers always reduces to a modulo-4 step.
module wb_burst_addr
  import wb_pkg::*;
(
  input  logic [IDX_W-1:0] i_curIdx,
  input  logic [1:0]       i_bte,
  output logic [IDX_W-1:0] o_nextIdx
);

  logic [IDX_W-1:0] w_mask;
  logic [IDX_W-1:0] w_step;

  always_comb begin
    w_mask    = IDX_W'(bteWrapMask(i_bte));
    w_step    = i_curIdx + 1'b1;
    o_nextIdx = (i_curIdx & ~w_mask) | (w_step & w_mask);
  end

endmodule

// File: rtl/wb_test_slave.sv
// Four-register Wishbone B3 test slave with byte-lane writes, registered
// read data/ack/err and incrementing-burst support.
module wb_test_slave
  import wb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          wb_clk,
  input  logic          wb_rst,
  wb_test_slave_if.slave bus
);

  localparam int NLANES = DW / 8;

  state_e           r_state;
  logic             r_ack;
  logic             r_err;
  logic [DW-1:0]    r_dat;
  logic [IDX_W-1:0] r_curIdx;
  logic [DW-1:0]    r_regs [NUM_REGS];

  logic             w_valid;
  logic             w_reserved;
  logic             w_isIncr;
  logic             w_writeEn;
  logic [IDX_W-1:0] w_reqIdx;
  logic [IDX_W-1:0] w_nextIdx;
  logic             w_unusedAdr;

  assign w_valid     = bus.wb_cyc_i & bus.wb_stb_i;
  assign w_reqIdx    = bus.wb_adr_i[3:2];
  assign w_reserved  = isReservedCti(bus.wb_cti_i);
  assign w_isIncr    = (bus.wb_cti_i == CTI_INCR);
  assign w_unusedAdr = ^{bus.wb_adr_i[AW-1:4], bus.wb_adr_i[1:0]};

  // A write lands on the edge where the master sees our ack, so its data is still on the bus.
  assign w_writeEn = (r_state != ST_IDLE) && r_ack && w_valid && bus.wb_we_i;

  wb_burst_addr u_burstAddr (
    .i_curIdx  (r_curIdx),
    .i_bte     (bus.wb_bte_i),
    .o_nextIdx (w_nextIdx)
  );

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      r_state  <= ST_IDLE;
      r_ack    <= 1'b0;
      r_err    <= 1'b0;
      r_dat    <= '0;
      r_curIdx <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_ack <= 1'b0;
          r_err <= 1'b0;
          if (w_valid && !r_ack) begin
            r_curIdx <= w_reqIdx;
            if (w_reserved) begin
              r_err   <= 1'b1;
              r_state <= ST_ACK;
            end else begin
              r_ack <= 1'b1;
              if (!bus.wb_we_i) r_dat <= r_regs[w_reqIdx];
              r_state <= w_isIncr ? ST_BURST : ST_ACK;
            end
          end
        end
        ST_ACK: begin
          r_ack   <= 1'b0;
          r_err   <= 1'b0;
          r_state <= ST_IDLE;
        end
        ST_BURST: begin
          r_err <= 1'b0;
          // The beat completing now still says INCR, so pre-ack the next one from the predicted index.
          if (w_valid && w_isIncr) begin
            r_ack    <= 1'b1;
            r_curIdx <= w_nextIdx;
            if (!bus.wb_we_i) r_dat <= r_regs[w_nextIdx];
          end else begin
            r_ack   <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_ack   <= 1'b0;
          r_err   <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (w_writeEn) begin
      for (int b = 0; b < NLANES; b++) begin
        if (bus.wb_sel_i[b]) r_regs[r_curIdx][8*b +: 8] <= bus.wb_dat_i[8*b +: 8];
      end
    end
  end

  assign bus.wb_dat_o = r_dat;
  assign bus.wb_ack_o = r_ack;
  assign bus.wb_err_o = r_err;
  assign bus.wb_rty_o = 1'b0;

endmodule

// File: tb/tb_wb_test_slave.sv
// Self-checking bench for wb_test_slave: directed transfers plus random traffic,
// with every output compared each cycle against a transaction-level model.
module tb_wb_test_slave;
  import wb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_test_slave_if #(.AW(AW), .DW(DW)) bus();

  wb_test_slave #(.AW(AW), .DW(DW)) dut (
    .wb_clk (clk),
    .wb_rst (rst),
    .bus    (bus)
  );

  int          total = 0;
  int          bad   = 0;
  logic [31:0] model [4];
  logic [31:0] expDat;
  logic        expAck;
  logic        expErr;
  logic        ackCare;
  logic        checkEn;
  logic [31:0] rd;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    total++;
    if (actual !== required) begin
      bad++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, required, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checkEn) begin
      if (ackCare) checkOutput("ack", 32'(bus.wb_ack_o), 32'(expAck));
      checkOutput("err", 32'(bus.wb_err_o), 32'(expErr));
      checkOutput("rty", 32'(bus.wb_rty_o), 32'd0);
      checkOutput("dat", bus.wb_dat_o, expDat);
    end
  end

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] sel);
    logic [31:0] m;
    m = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    return (old & ~m) | (d & m);
  endfunction

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idleBus();
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.wb_we_i  = 1'b0;
    bus.wb_adr_i = '0;
    bus.wb_dat_i = '0;
    bus.wb_sel_i = '0;
    bus.wb_cti_i = 3'b000;
    bus.wb_bte_i = 2'b00;
  endtask

  // Request cycle, response cycle, then release (optionally holding stb one extra cycle).
  task automatic classicXfer(input logic [31:0] adr, input logic we, input logic [31:0] d,
                             input logic [3:0] sel, input logic [2:0] cti, input logic holdStb,
                             output logic [31:0] rdata);
    logic [1:0] idx;
    logic       isErr;
    idx   = adr[3:2];
    isErr = (cti inside {3'b011, 3'b100, 3'b101, 3'b110});
    nextCycle();
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = we;
    bus.wb_adr_i = adr;  bus.wb_dat_i = d;    bus.wb_sel_i = sel;
    bus.wb_cti_i = cti;  bus.wb_bte_i = 2'($urandom);
    expAck = 1'b0; expErr = 1'b0;
    nextCycle();
    expAck = !isErr;
    expErr = isErr;
    if (!isErr && !we) expDat = model[idx];
    @(negedge clk);
    #1 rdata = bus.wb_dat_o;
    nextCycle();
    if (!isErr && we) model[idx] = merge(model[idx], d, sel);
    expAck = 1'b0; expErr = 1'b0;
    if (holdStb) begin
      nextCycle();
      idleBus();
      ackCare = 1'b0;
      nextCycle();
      ackCare = 1'b1;
    end else begin
      idleBus();
    end
  endtask

  // Beat k is acked in cycle k+1; dropAt/rstAt (cycle numbers, -1 = never) abort the burst.
  task automatic burstXfer(input logic [31:0] adr, input int n, input logic we, input logic [3:0] sel,
                           input logic [1:0] bte, input int dropAt, input int rstAt);
    logic [1:0]  s, wi, ri;
    logic [31:0] d [8];
    bit          completing, stopping, wasReset;
    int          k;
    s = adr[3:2];
    for (int i = 0; i < 8; i++) d[i] = $urandom;
    completing = 0; stopping = 0; wasReset = 0;
    for (int c = 0; c <= n + 1; c++) begin
      nextCycle();
      if (completing && we) begin
        wi = s + 2'(c - 2);
        model[wi] = merge(model[wi], d[c-2], sel);
      end
      if (wasReset) begin
        rst = 1'b0;
        for (int i = 0; i < 4; i++) model[i] = '0;
        expDat = '0;
      end
      expErr = 1'b0;
      if (c == 0) expAck = 1'b0;
      else if (stopping || c > n) expAck = 1'b0;
      else begin
        expAck = 1'b1;
        if (!we) begin
          ri = s + 2'(c - 1);
          expDat = model[ri];
        end
      end
      if (stopping || c > n) begin
        idleBus();
        break;
      end
      k = (c <= 1) ? 0 : c - 1;
      if (c == rstAt) begin
        rst = 1'b1; idleBus();
        completing = 0; stopping = 1; wasReset = 1;
      end else if (c == dropAt) begin
        bus.wb_stb_i = 1'b0;
        completing = 0; stopping = 1;
      end else begin
        bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = we;
        bus.wb_adr_i = {adr[31:4], s + 2'(k), 2'b00};
        bus.wb_dat_i = d[k]; bus.wb_sel_i = sel; bus.wb_bte_i = bte;
        bus.wb_cti_i = (k == n - 1) ? 3'b111 : 3'b010;
        completing = (c >= 1);
      end
    end
  endtask

  task automatic applyStimulus(input int count);
    logic [2:0]  ctiSet [3];
    logic [31:0] adr, d, r;
    int          kind, n, drop;
    ctiSet = '{3'b000, 3'b001, 3'b111};
    for (int t = 0; t < count; t++) begin
      kind = $urandom_range(0, 9);
      adr  = $urandom;
      d    = $urandom;
      if (kind <= 3)
        classicXfer(adr, 1'b1, d, 4'($urandom), ctiSet[$urandom_range(0, 2)], 1'b0, r);
      else if (kind <= 5)
        classicXfer(adr, 1'b0, d, 4'hF, ctiSet[$urandom_range(0, 2)], ($urandom_range(0, 3) == 0), r);
      else if (kind == 6)
        classicXfer(adr, 1'($urandom), d, 4'hF, 3'($urandom_range(3, 6)), 1'b0, r);
      else begin
        n    = $urandom_range(2, 6);
        drop = ($urandom_range(0, 4) == 0) ? $urandom_range(1, n) : -1;
        burstXfer(adr, n, 1'($urandom), 4'($urandom), 2'($urandom), drop, -1);
      end
      if ($urandom_range(0, 2) == 0) nextCycle();
    end
  endtask

  initial begin
    logic [31:0] wrAdr [4];
    logic [31:0] wrDat [4];
    wrAdr = '{32'h9000_0000, 32'h9000_0004, 32'h9000_0008, 32'h9000_000C};
    wrDat = '{32'hDEADBEEF, 32'hF00DD00F, 32'h01234567, 32'h89ABCDEF};
    checkEn = 1'b0; ackCare = 1'b1;
    expAck = 1'b0; expErr = 1'b0; expDat = '0;
    for (int i = 0; i < 4; i++) model[i] = '0;
    idleBus();
    rst = 1'b1;
    nextCycle();
    checkEn = 1'b1;
    nextCycle();
    nextCycle();
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      classicXfer(wrAdr[i], 1'b0, '0, 4'hF, 3'b000, 1'b0, rd);
      checkOutput("resetRead", rd, 32'h0);
    end
    for (int i = 0; i < 4; i++) classicXfer(wrAdr[i], 1'b1, wrDat[i], 4'hF, 3'b000, 1'b0, rd);
    for (int i = 0; i < 4; i++) begin
      classicXfer(wrAdr[i], 1'b0, '0, 4'hF, 3'b111, 1'b0, rd);
      checkOutput("wordRead", rd, wrDat[i]);
    end

    burstXfer(32'h9000_0008, 4, 1'b0, 4'hF, 2'b00, -1, -1);
    @(negedge clk);
    checkOutput("burstLast", bus.wb_dat_o, 32'hF00DD00F);

    classicXfer(32'h9000_0000, 1'b1, 32'h11223344, 4'h5, 3'b000, 1'b0, rd);
    classicXfer(32'h9000_0000, 1'b0, '0, 4'hF, 3'b111, 1'b0, rd);
    checkOutput("laneRead", rd, 32'hDE22BE44);

    classicXfer(32'h9000_0004, 1'b0, '0, 4'hF, 3'b000, 1'b1, rd);
    classicXfer(32'h9000_0000, 1'b1, 32'h0, 4'hF, 3'b011, 1'b0, rd);
    classicXfer(32'h9000_0000, 1'b0, '0, 4'hF, 3'b000, 1'b0, rd);
    checkOutput("errNoWrite", rd, 32'hDE22BE44);

    applyStimulus(60);

    burstXfer(32'h9000_0000, 4, 1'b1, 4'hF, 2'b01, 3, -1);
    for (int i = 0; i < 4; i++) classicXfer(wrAdr[i], 1'b0, '0, 4'hF, 3'b000, 1'b0, rd);

    burstXfer(32'h9000_0004, 4, 1'b0, 4'hF, 2'b00, -1, 2);
    for (int i = 0; i < 4; i++) begin
      classicXfer(wrAdr[i], 1'b0, '0, 4'hF, 3'b000, 1'b0, rd);
      checkOutput("postResetRead", rd, 32'h0);
    end

    nextCycle();
    checkEn = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
